// File: rtl/pipe_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | pipe_ctrl_pkg                                                        |
// | Shared types and constants for the pipeline hazard controller.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_FETCH   = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM result is younger than WB, so it wins when both match.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic       we_m,
    input logic [4:0] rd_w,
    input logic       we_w
  );
    if (we_m && (rd_m != REG_ZERO) && (rd_m == rs))
      return FWD_MEM;
    else if (we_w && (rd_w != REG_ZERO) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +----------------------------------------------------------------------+
// | sat_counter                                                          |
// | Event counter that sticks at all-ones; synchronous clear wins.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_count <= '0;
    else if (clr)
      r_count <= '0;
    else if (inc && (r_count != C_MAX))
      r_count <= r_count + C_ONE;
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | hazard_ctrl                                                          |
// | Stall/flush/forward control and fetch sequencing for the 5-stage     |
// | RV32I pipeline, with saturating activity counters.                   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic             ResultSrcE0,
  input  logic             RegWriteE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             imem_ready,
  input  logic             cnt_clr,
  output logic             imem_req,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] lu_stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] fetch_wait_cnt
);

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic         w_lw_stall;
  logic         w_fetch_wait;

  assign w_lw_stall = ResultSrcE0 & RegWriteE & (RdE != REG_ZERO) &
                      ((Rs1D == RdE) | (Rs2D == RdE));

  assign ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
  assign ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= F_IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    w_fetch_wait = 1'b0;
    StallF       = 1'b0;
    StallD       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;

    case (r_state)
      F_IDLE:    w_next_state = F_FETCH;
      F_FETCH: begin
        imem_req     = 1'b1;
        w_fetch_wait = ~imem_ready;
        // PC already took the target; the in-flight response is now stale.
        if (PCSrcE && !imem_ready)
          w_next_state = F_DISCARD;
      end
      F_DISCARD: begin
        if (imem_ready)
          w_next_state = F_FETCH;
      end
      default:   w_next_state = F_IDLE;
    endcase

    if (PCSrcE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_lw_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (w_fetch_wait) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end

    // No valid instruction arrives outside F_FETCH, so ID gets a bubble
    // unless a load-use hazard must hold the instruction already there.
    if ((r_state != F_FETCH) && !(w_lw_stall && !PCSrcE)) begin
      FlushD = 1'b1;
      StallF = ~PCSrcE;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_lu_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (StallD),
    .count   (lu_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (PCSrcE),
    .count   (redirect_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fetch_wait_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (cnt_clr),
    .inc     (w_fetch_wait),
    .count   (fetch_wait_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl                                                       |
// | Directed vector table plus hand sequences for hazard_ctrl.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_hazard_ctrl;

  localparam int CNT_W = 3;

  logic clk;
  logic reset_n;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic ResultSrcE0, RegWriteE, PCSrcE, RegWriteM, RegWriteW;
  logic imem_ready, cnt_clr;
  logic imem_req, StallF, StallD, FlushD, FlushE;
  logic [1:0] ForwardAE, ForwardBE;
  logic [CNT_W-1:0] lu_stall_cnt, redirect_cnt, fetch_wait_cnt;

  logic [4:0] w_ctrl;
  assign w_ctrl = {imem_req, StallF, StallD, FlushD, FlushE};

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .Rs1D           (Rs1D),
    .Rs2D           (Rs2D),
    .Rs1E           (Rs1E),
    .Rs2E           (Rs2E),
    .RdE            (RdE),
    .ResultSrcE0    (ResultSrcE0),
    .RegWriteE      (RegWriteE),
    .PCSrcE         (PCSrcE),
    .RdM            (RdM),
    .RdW            (RdW),
    .RegWriteM      (RegWriteM),
    .RegWriteW      (RegWriteW),
    .imem_ready     (imem_ready),
    .cnt_clr        (cnt_clr),
    .imem_req       (imem_req),
    .StallF         (StallF),
    .StallD         (StallD),
    .FlushD         (FlushD),
    .FlushE         (FlushE),
    .ForwardAE      (ForwardAE),
    .ForwardBE      (ForwardBE),
    .lu_stall_cnt   (lu_stall_cnt),
    .redirect_cnt   (redirect_cnt),
    .fetch_wait_cnt (fetch_wait_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  // Control vector order: {imem_req, StallF, StallD, FlushD, FlushE}
  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic       lde, rwe, rwm, rww;
    logic [4:0] ctrl;
    logic [1:0] fa, fb;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
    ResultSrcE0 = 0; RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
    PCSrcE = 0;
  endtask

  task automatic clear_counters();
    @(negedge clk);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("clr_lu", 32'(lu_stall_cnt), 0);
    chk("clr_redirect", 32'(redirect_cnt), 0);
    chk("clr_fetch_wait", 32'(fetch_wait_cnt), 0);
  endtask

  initial begin
    //         rs1d rs2d rs1e rs2e rde rdm rdw  lde rwe rwm rww  ctrl      fa     fb
    tbl[0]  = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 5'd0,  5'd0, 0, 0, 0, 0, 5'b10000, 2'b00, 2'b00};
    tbl[1]  = '{5'd0, 5'd5, 5'd0,  5'd0,  5'd5, 5'd0,  5'd0, 1, 1, 0, 0, 5'b11101, 2'b00, 2'b00};
    tbl[2]  = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 5'd0,  5'd0, 1, 1, 0, 0, 5'b10000, 2'b00, 2'b00};
    tbl[3]  = '{5'd9, 5'd0, 5'd0,  5'd0,  5'd9, 5'd0,  5'd0, 1, 1, 0, 0, 5'b11101, 2'b00, 2'b00};
    tbl[4]  = '{5'd9, 5'd0, 5'd0,  5'd0,  5'd9, 5'd0,  5'd0, 1, 0, 0, 0, 5'b10000, 2'b00, 2'b00};
    tbl[5]  = '{5'd9, 5'd0, 5'd0,  5'd0,  5'd9, 5'd0,  5'd0, 0, 1, 0, 0, 5'b10000, 2'b00, 2'b00};
    tbl[6]  = '{5'd0, 5'd0, 5'd7,  5'd0,  5'd0, 5'd7,  5'd7, 0, 0, 1, 1, 5'b10000, 2'b10, 2'b00};
    tbl[7]  = '{5'd0, 5'd0, 5'd7,  5'd0,  5'd0, 5'd7,  5'd7, 0, 0, 0, 1, 5'b10000, 2'b01, 2'b00};
    tbl[8]  = '{5'd0, 5'd0, 5'd4,  5'd3,  5'd0, 5'd4,  5'd3, 0, 0, 1, 1, 5'b10000, 2'b10, 2'b01};
    tbl[9]  = '{5'd0, 5'd0, 5'd0,  5'd0,  5'd0, 5'd0,  5'd0, 0, 0, 1, 1, 5'b10000, 2'b00, 2'b00};
    tbl[10] = '{5'd0, 5'd0, 5'd12, 5'd12, 5'd0, 5'd12, 5'd0, 0, 0, 1, 0, 5'b10000, 2'b10, 2'b10};
    tbl[11] = '{5'd0, 5'd0, 5'd6,  5'd6,  5'd0, 5'd5,  5'd6, 0, 0, 1, 1, 5'b10000, 2'b01, 2'b01};
    tbl[12] = '{5'd0, 5'd0, 5'd6,  5'd6,  5'd0, 5'd6,  5'd6, 0, 0, 0, 0, 5'b10000, 2'b00, 2'b00};

    clear_inputs();
    imem_ready = 1'b1;
    cnt_clr    = 1'b0;
    reset_n    = 1'b0;

    // Reset state
    #2;
    chk("reset_ctrl", 32'(w_ctrl), 32'(5'b01010));
    chk("reset_fwd", 32'({ForwardAE, ForwardBE}), 0);
    chk("reset_cnts", 32'({lu_stall_cnt, redirect_cnt, fetch_wait_cnt}), 0);

    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #2;
    chk("release_cycle1", 32'(w_ctrl), 32'(5'b01010));
    @(posedge clk); #1;
    chk("release_cycle2", 32'(w_ctrl), 32'(5'b10000));

    // Combinational vectors in F_FETCH with the fetch completing each cycle
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      Rs1D = tbl[i].rs1d; Rs2D = tbl[i].rs2d; Rs1E = tbl[i].rs1e; Rs2E = tbl[i].rs2e;
      RdE = tbl[i].rde; RdM = tbl[i].rdm; RdW = tbl[i].rdw;
      ResultSrcE0 = tbl[i].lde; RegWriteE = tbl[i].rwe;
      RegWriteM = tbl[i].rwm; RegWriteW = tbl[i].rww;
      #1;
      chk($sformatf("vec%0d_ctrl", i), 32'(w_ctrl), 32'(tbl[i].ctrl));
      chk($sformatf("vec%0d_fwdA", i), 32'(ForwardAE), 32'(tbl[i].fa));
      chk($sformatf("vec%0d_fwdB", i), 32'(ForwardBE), 32'(tbl[i].fb));
    end
    @(negedge clk);
    clear_inputs();
    chk("table_lu_cnt", 32'(lu_stall_cnt), 2);
    chk("table_redirect_cnt", 32'(redirect_cnt), 0);
    clear_counters();

    // Load-use, then the same with RdE = x0
    @(negedge clk);
    RdE = 5'd5; Rs2D = 5'd5; ResultSrcE0 = 1; RegWriteE = 1;
    #1;
    chk("lu_ctrl", 32'(w_ctrl), 32'(5'b11101));
    @(posedge clk); #1;
    chk("lu_cnt", 32'(lu_stall_cnt), 1);
    @(negedge clk);
    RdE = 5'd0;
    #1;
    chk("lu_x0_ctrl", 32'(w_ctrl), 32'(5'b10000));
    @(posedge clk); #1;
    chk("lu_x0_cnt", 32'(lu_stall_cnt), 1);

    // Redirect takes precedence over load-use
    @(negedge clk);
    RdE = 5'd5; PCSrcE = 1;
    #1;
    chk("redir_lu_ctrl", 32'(w_ctrl), 32'(5'b10011));
    @(posedge clk); #1;
    chk("redir_cnt", 32'(redirect_cnt), 1);
    chk("redir_lu_cnt", 32'(lu_stall_cnt), 1);
    @(negedge clk);
    clear_inputs();

    // Redirect while a fetch is outstanding
    clear_counters();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      imem_ready = 1'b0;
      #1;
      chk($sformatf("wait%0d_ctrl", k), 32'(w_ctrl), 32'(5'b11010));
    end
    @(negedge clk);
    PCSrcE = 1'b1;
    #1;
    chk("wait_redir_ctrl", 32'(w_ctrl), 32'(5'b10011));
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    chk("discard1_ctrl", 32'(w_ctrl), 32'(5'b01010));
    @(negedge clk);
    #1;
    chk("discard2_ctrl", 32'(w_ctrl), 32'(5'b01010));
    @(negedge clk);
    imem_ready = 1'b1;
    #1;
    chk("discard_drop_ctrl", 32'(w_ctrl), 32'(5'b01010));
    @(negedge clk);
    #1;
    chk("refetch_ctrl", 32'(w_ctrl), 32'(5'b10000));
    chk("wait_fw_cnt", 32'(fetch_wait_cnt), 4);
    chk("wait_redir_cnt", 32'(redirect_cnt), 1);

    // Saturation of a 3-bit counter, then clear overriding an increment
    clear_counters();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      PCSrcE = 1'b1;
      @(negedge clk);
      PCSrcE = 1'b0;
      if (k == 6) chk("sat_at7", 32'(redirect_cnt), 7);
    end
    chk("sat_after9", 32'(redirect_cnt), 7);
    @(negedge clk);
    cnt_clr = 1'b1;
    PCSrcE  = 1'b1;
    @(posedge clk); #1;
    chk("sat_clr", 32'(redirect_cnt), 0);
    cnt_clr = 1'b0;
    PCSrcE  = 1'b0;

    // Asynchronous reset while discarding
    clear_counters();
    @(negedge clk);
    imem_ready = 1'b0;
    @(negedge clk);
    PCSrcE = 1'b1;
    @(negedge clk);
    PCSrcE = 1'b0;
    #1;
    chk("pre_rst_discard", 32'(w_ctrl), 32'(5'b01010));
    chk("pre_rst_fw_cnt", 32'(fetch_wait_cnt), 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", 32'(w_ctrl), 32'(5'b01010));
    chk("async_rst_cnt", 32'({lu_stall_cnt, redirect_cnt, fetch_wait_cnt}), 0);
    @(negedge clk);
    reset_n    = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk("rerelease_cycle1", 32'(w_ctrl), 32'(5'b01010));
    @(posedge clk); #1;
    chk("rerelease_cycle2", 32'(w_ctrl), 32'(5'b10000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
